// File: rtl/rotating_arbiter_n.sv
// rtl/rotating_arbiter_n.sv - N-way round-robin arbiter with per-polarity pointer and packet lock
module rotating_arbiter_n #(
    parameter int N          = 4,
    parameter int LOCK_EN    = 1,
    parameter int IDLE_RESET = 1,
    localparam int IW        = (N > 2) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          polarity,
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  last,
    input  logic          ready,
    output logic [N-1:0]  grant,
    output logic          grant_valid,
    output logic [IW-1:0] grant_idx,
    output logic          lock_active
);

    // Two independent contexts; only the one picked by polarity is touched.
    logic [IW-1:0] ptr_q   [2];
    logic          lock_q  [2];
    logic [IW-1:0] owner_q [2];

    logic [IW-1:0] cur_ptr;
    logic [IW-1:0] cur_owner;
    logic          cur_lock;

    logic [N-1:0]  grant_c;
    logic [IW-1:0] idx_c;
    logic          hit_c;
    logic          xfer;
    logic          multi_req;
    logic [N-1:0]  req_m1;

    logic [IW-1:0] ptr_n;
    logic [IW-1:0] owner_n;
    logic          lock_n;

    assign cur_ptr   = ptr_q[polarity];
    assign cur_owner = owner_q[polarity];
    assign cur_lock  = lock_q[polarity];

    // Clearing the lowest set bit leaves something only if two or more requests are up.
    assign req_m1    = req - {{(N-1){1'b0}}, 1'b1};
    assign multi_req = |(req & req_m1);

    assign xfer = hit_c && ready;

    // Grant selection: locked owner only, else first request at or after the pointer.
    always_comb begin
        int            pos;
        logic [IW-1:0] sel;
        grant_c = '0;
        idx_c   = '0;
        hit_c   = 1'b0;
        pos     = 0;
        sel     = '0;
        if (cur_lock) begin
            if (req[cur_owner]) begin
                grant_c[cur_owner] = 1'b1;
                idx_c              = cur_owner;
                hit_c              = 1'b1;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                pos = int'(cur_ptr) + k;
                if (pos >= N) begin
                    pos = pos - N;
                end
                sel = IW'(pos);
                if (!hit_c && req[sel]) begin
                    grant_c[sel] = 1'b1;
                    idx_c        = sel;
                    hit_c        = 1'b1;
                end
            end
        end
    end

    // Next state of the active context: lock on a head flit, release and rotate on a tail.
    always_comb begin
        ptr_n   = cur_ptr;
        lock_n  = cur_lock;
        owner_n = cur_owner;
        if (xfer) begin
            if (LOCK_EN != 0 && !last[idx_c]) begin
                lock_n  = 1'b1;
                owner_n = idx_c;
            end else begin
                lock_n = 1'b0;
                ptr_n  = (idx_c == IW'(N - 1)) ? '0 : idx_c + IW'(1);
            end
        end
        // With at most one contender the pointer carries no fairness history, so park it at 0.
        if (IDLE_RESET != 0 && !cur_lock && !multi_req) begin
            ptr_n = '0;
        end
    end

    // Context state registers; the inactive context holds.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < 2; c++) begin
                ptr_q[c]   <= '0;
                lock_q[c]  <= 1'b0;
                owner_q[c] <= '0;
            end
        end else begin
            ptr_q[polarity]   <= ptr_n;
            lock_q[polarity]  <= lock_n;
            owner_q[polarity] <= owner_n;
        end
    end

    assign grant       = reset ? grant_c : '0;
    assign grant_valid = reset & hit_c;
    assign grant_idx   = reset ? idx_c : '0;
    assign lock_active = reset & cur_lock;

endmodule

// File: tb/tb_rotating_arbiter_n.sv
// tb/tb_rotating_arbiter_n.sv - scoreboard bench for rotating_arbiter_n in three configurations
module tb_rotating_arbiter_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Driven DUT inputs (index 0: N4 lock+idle, 1: N4 free-running, 2: N3 lock only)
    logic       rst_n;
    logic       d_pol  [3];
    logic [3:0] d_req  [3];
    logic [3:0] d_last [3];
    logic       d_rdy  [3];

    // Staged stimulus, copied onto the DUT inputs just after each rising edge
    logic       s_rst;
    logic       s_pol  [3];
    logic [3:0] s_req  [3];
    logic [3:0] s_last [3];
    logic       s_rdy  [3];

    logic [3:0] g_a, g_b;
    logic [2:0] g_c;
    logic       gv_a, gv_b, gv_c;
    logic [1:0] gi_a, gi_b, gi_c;
    logic       lk_a, lk_b, lk_c;

    rotating_arbiter_n #(.N(4), .LOCK_EN(1), .IDLE_RESET(1)) u_a (
        .clk(clk), .reset(rst_n), .polarity(d_pol[0]), .req(d_req[0]), .last(d_last[0]),
        .ready(d_rdy[0]), .grant(g_a), .grant_valid(gv_a), .grant_idx(gi_a), .lock_active(lk_a)
    );

    rotating_arbiter_n #(.N(4), .LOCK_EN(0), .IDLE_RESET(0)) u_b (
        .clk(clk), .reset(rst_n), .polarity(d_pol[1]), .req(d_req[1]), .last(d_last[1]),
        .ready(d_rdy[1]), .grant(g_b), .grant_valid(gv_b), .grant_idx(gi_b), .lock_active(lk_b)
    );

    rotating_arbiter_n #(.N(3), .LOCK_EN(1), .IDLE_RESET(0)) u_c (
        .clk(clk), .reset(rst_n), .polarity(d_pol[2]), .req(d_req[2][2:0]), .last(d_last[2][2:0]),
        .ready(d_rdy[2]), .grant(g_c), .grant_valid(gv_c), .grant_idx(gi_c), .lock_active(lk_c)
    );

    typedef struct {
        int         d;
        logic [3:0] g;
        logic       v;
        logic [1:0] idx;
        logic       lk;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int checks = 0;
    int errors = 0;

    int cfg_n  [3] = '{4, 4, 3};
    int cfg_le [3] = '{1, 0, 1};
    int cfg_ir [3] = '{1, 0, 0};

    // Reference state: pointer, lock flag and owner for each DUT and each polarity
    int m_ptr  [3][2];
    int m_lock [3][2];
    int m_own  [3][2];

    function automatic void get_out(input int d, output logic [3:0] g, output logic v,
                                    output logic [1:0] idx, output logic lk);
        case (d)
            0:       begin g = g_a;          v = gv_a; idx = gi_a; lk = lk_a; end
            1:       begin g = g_b;          v = gv_b; idx = gi_b; lk = lk_b; end
            default: begin g = {1'b0, g_c};  v = gv_c; idx = gi_c; lk = lk_c; end
        endcase
    endfunction

    // Predict this cycle's outputs from the rules, queue them, then advance the reference state.
    task automatic model_step(input int d);
        exp_t e;
        int   p, n, gsel, cnt, idx;
        e.d = d;
        if (!rst_n) begin
            for (int c = 0; c < 2; c++) begin
                m_ptr[d][c]  = 0;
                m_lock[d][c] = 0;
                m_own[d][c]  = 0;
            end
            e.g = '0; e.v = 1'b0; e.idx = '0; e.lk = 1'b0;
        end else begin
            p    = int'(d_pol[d]);
            n    = cfg_n[d];
            gsel = -1;
            cnt  = 0;
            for (int i = 0; i < n; i++) cnt += int'(d_req[d][i]);
            if (m_lock[d][p] != 0) begin
                if (d_req[d][m_own[d][p]]) gsel = m_own[d][p];
            end else begin
                for (int k = 0; k < n; k++) begin
                    idx = (m_ptr[d][p] + k) % n;
                    if (gsel < 0 && d_req[d][idx]) gsel = idx;
                end
            end
            e.v   = (gsel >= 0);
            e.g   = (gsel >= 0) ? 4'(1 << gsel) : 4'd0;
            e.idx = (gsel >= 0) ? 2'(gsel) : 2'd0;
            e.lk  = (m_lock[d][p] != 0);
            if (gsel >= 0 && d_rdy[d]) begin
                if (cfg_le[d] != 0 && !d_last[d][gsel]) begin
                    m_own[d][p] = gsel;
                    if (m_lock[d][p] == 0 && cfg_ir[d] != 0 && cnt < 2) m_ptr[d][p] = 0;
                    m_lock[d][p] = 1;
                end else begin
                    m_ptr[d][p] = (gsel + 1) % n;
                    if (m_lock[d][p] == 0 && cfg_ir[d] != 0 && cnt < 2) m_ptr[d][p] = 0;
                    m_lock[d][p] = 0;
                end
            end else if (m_lock[d][p] == 0 && cfg_ir[d] != 0 && cnt < 2) begin
                m_ptr[d][p] = 0;
            end
        end
        sb_q.push_back(e);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        rst_n = s_rst;
        for (int d = 0; d < 3; d++) begin
            d_pol[d]  = s_pol[d];
            d_req[d]  = s_req[d];
            d_last[d] = s_last[d];
            d_rdy[d]  = s_rdy[d];
        end
        for (int d = 0; d < 3; d++) model_step(d);
    endtask

    task automatic set_s(input int d, input logic pol, input logic [3:0] rq,
                         input logic [3:0] ls, input logic rdy);
        s_pol[d]  = pol;
        s_req[d]  = rq;
        s_last[d] = ls;
        s_rdy[d]  = rdy;
    endtask

    // Directed check against a hand-derived constant, taken mid-cycle.
    task automatic dchk(input string nm, input int d, input int ei, input logic ev, input logic el);
        logic [3:0] g;
        logic       v;
        logic [1:0] idx;
        logic       lk;
        #2;
        get_out(d, g, v, idx, lk);
        checks++;
        if (idx !== 2'(ei) || v !== ev || lk !== el) begin
            errors++;
            $display("FAIL %s: got idx=%0d valid=%b lock=%b, want idx=%0d valid=%b lock=%b",
                     nm, idx, v, lk, ei, ev, el);
        end
    endtask

    // Scoreboard monitor: compare every queued expectation away from the active edge
    always @(negedge clk) begin
        logic [3:0] g;
        logic       v;
        logic [1:0] idx;
        logic       lk;
        while (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            get_out(mon_e.d, g, v, idx, lk);
            checks++;
            if (g !== mon_e.g || v !== mon_e.v || idx !== mon_e.idx || lk !== mon_e.lk) begin
                errors++;
                $display("FAIL sb dut%0d t=%0t: got g=%b v=%b idx=%0d lk=%b, want g=%b v=%b idx=%0d lk=%b",
                         mon_e.d, $time, g, v, idx, lk, mon_e.g, mon_e.v, mon_e.idx, mon_e.lk);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        s_rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            d_pol[d] = 1'b0; d_req[d] = '0; d_last[d] = '0; d_rdy[d] = 1'b0;
            set_s(d, 1'b0, 4'b0000, 4'b0000, 1'b0);
        end

        // Reset holds outputs at zero even with requests present
        cycle();
        for (int d = 0; d < 3; d++) set_s(d, 1'b0, (d == 2) ? 4'b0111 : 4'b1111, 4'b0000, 1'b1);
        cycle();
        dchk("reset_a", 0, 0, 1'b0, 1'b0);
        dchk("reset_b", 1, 0, 1'b0, 1'b0);
        for (int d = 0; d < 3; d++) set_s(d, 1'b0, 4'b0000, 4'b0000, 1'b0);
        s_rst = 1'b1;

        // Free-running rotation, then skip over non-requesters
        set_s(1, 1'b0, 4'b1111, 4'b1111, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle();
            dchk($sformatf("rr%0d", i), 1, i % 4, 1'b1, 1'b0);
        end
        cycle();
        dchk("rr5", 1, 1, 1'b1, 1'b0);
        set_s(1, 1'b0, 4'b1010, 4'b1010, 1'b1);
        cycle();
        dchk("skip_p2", 1, 3, 1'b1, 1'b0);
        cycle();
        dchk("skip_wrap", 1, 1, 1'b1, 1'b0);
        set_s(1, 1'b0, 4'b0000, 4'b0000, 1'b0);

        // Three-flit packet from requester 0 while requester 1 waits
        set_s(0, 1'b0, 4'b0011, 4'b0000, 1'b1);
        cycle();
        dchk("pkt_head", 0, 0, 1'b1, 1'b0);
        cycle();
        dchk("pkt_body", 0, 0, 1'b1, 1'b1);
        set_s(0, 1'b0, 4'b0011, 4'b0001, 1'b1);
        cycle();
        dchk("pkt_tail", 0, 0, 1'b1, 1'b1);
        set_s(0, 1'b0, 4'b0011, 4'b0000, 1'b0);
        cycle();
        dchk("pkt_next", 0, 1, 1'b1, 1'b0);

        // Polarity isolation: context 0 locked on 2, context 1 rotates on its own
        set_s(0, 1'b0, 4'b0100, 4'b0000, 1'b1);
        cycle();
        dchk("pol_lock", 0, 2, 1'b1, 1'b0);
        set_s(0, 1'b1, 4'b1111, 4'b1111, 1'b1);
        cycle();
        dchk("pol1_a", 0, 0, 1'b1, 1'b0);
        cycle();
        dchk("pol1_b", 0, 1, 1'b1, 1'b0);
        set_s(0, 1'b0, 4'b1111, 4'b1111, 1'b0);
        cycle();
        dchk("pol0_back", 0, 2, 1'b1, 1'b1);
        set_s(0, 1'b0, 4'b0100, 4'b0100, 1'b1);
        cycle();
        dchk("pol0_tail", 0, 2, 1'b1, 1'b1);

        // Downstream stall keeps the grant and the pointer
        set_s(0, 1'b0, 4'b0110, 4'b0110, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            dchk($sformatf("stall%0d", i), 0, 1, 1'b1, 1'b0);
        end
        set_s(0, 1'b0, 4'b0110, 4'b0110, 1'b1);
        cycle();
        dchk("stall_go", 0, 1, 1'b1, 1'b0);
        cycle();
        dchk("stall_next", 0, 2, 1'b1, 1'b0);

        // Idle reset: pointer at 3, a lone request sends it back to 0
        set_s(0, 1'b0, 4'b0100, 4'b0100, 1'b1);
        cycle();
        dchk("idle_x", 0, 2, 1'b1, 1'b0);
        set_s(0, 1'b0, 4'b1111, 4'b1111, 1'b0);
        cycle();
        dchk("idle_ptr0", 0, 0, 1'b1, 1'b0);

        // Reset in the middle of a locked packet
        set_s(0, 1'b0, 4'b0010, 4'b0000, 1'b1);
        cycle();
        dchk("mid_head", 0, 1, 1'b1, 1'b0);
        set_s(0, 1'b0, 4'b1111, 4'b1111, 1'b0);
        cycle();
        dchk("mid_locked", 0, 1, 1'b1, 1'b1);
        s_rst = 1'b0;
        cycle();
        dchk("mid_rst", 0, 0, 1'b0, 1'b0);
        s_rst = 1'b1;
        cycle();
        dchk("mid_release", 0, 0, 1'b1, 1'b0);

        // Randomized traffic on all three configurations
        for (int i = 0; i < 3000; i++) begin
            for (int d = 0; d < 3; d++) begin
                s_pol[d]  = 1'($urandom_range(0, 1));
                s_req[d]  = 4'($urandom_range(0, 15)) & ((d == 2) ? 4'b0111 : 4'b1111);
                s_last[d] = 4'($urandom_range(0, 15));
                s_rdy[d]  = ($urandom_range(0, 3) != 0);
            end
            s_rst = ($urandom_range(0, 299) != 0);
            cycle();
        end

        s_rst = 1'b1;
        for (int d = 0; d < 3; d++) set_s(d, 1'b0, 4'b0000, 4'b0000, 1'b0);
        cycle();
        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending entries, want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
